// File: rtl/vmem_scanout.sv
// vmem_scanout: 640x480@60 raster scan-out of the shared video memory with registered sync/DE/RGB.
// Optional define VMEM_SCAN_SCALE_EN replicates each vmem pixel 2^SCALE_LOG2 x 2^SCALE_LOG2.
module vmem_scanout #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int VMEM_ADDRW  = 15,
  parameter int VMEM_WDATAW = 3,
  parameter int SCALE_LOG2  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  output logic [VMEM_ADDRW-1:0]  vmem_raddr_o,
  input  logic [VMEM_WDATAW-1:0] vmem_rdata_i,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   de_o,
  output logic [VMEM_WDATAW-1:0] rgb_o,
  output logic                   frame_start_o
);

  localparam logic [9:0] H_ACT    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_ACT    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_LAST   = 10'd524;

`ifdef VMEM_SCAN_SCALE_EN
  localparam int S = SCALE_LOG2;
`else
  localparam int S = 0 * SCALE_LOG2;
  localparam logic [9:0] WIN_W = 10'(FB_W);
  localparam logic [9:0] WIN_H = 10'(FB_H);
`endif

  // Low S bits of vcnt select the replicated row; line base steps when they roll over.
  localparam logic [9:0]            Y_MASK    = 10'((1 << S) - 1);
  localparam logic [VMEM_ADDRW-1:0] LINE_STEP = VMEM_ADDRW'(FB_W);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic de;
    logic fs;
    logic win;
  } tim_t;

  localparam tim_t TIM_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0, fs: 1'b0, win: 1'b0};

  state_t                  state_q, state_d;
  logic [9:0]              hcnt_q, vcnt_q;
  logic [VMEM_ADDRW-1:0]   line_base_q;
  logic                    h_last, v_last, frame_end;
  tim_t                    s0, s1_q;
  logic [VMEM_ADDRW-1:0]   addr_s0;

  assign h_last    = (hcnt_q == H_LAST);
  assign v_last    = (vcnt_q == V_LAST);
  assign frame_end = h_last && v_last;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_RUN;
      ST_RUN:  if (frame_end && !en_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster counters plus the running y*FB_W line base, all frozen at zero while idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || state_q == ST_IDLE) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      line_base_q <= '0;
    end else if (h_last) begin
      hcnt_q <= '0;
      if (v_last) begin
        vcnt_q      <= '0;
        line_base_q <= '0;
      end else begin
        vcnt_q <= vcnt_q + 10'd1;
        if (((vcnt_q + 10'd1) & Y_MASK) == '0) begin
          line_base_q <= line_base_q + LINE_STEP;
        end
      end
    end else begin
      hcnt_q <= hcnt_q + 10'd1;
    end
  end

  // Stage 0: decode timing and window from the counters, form the read address.
  always_comb begin
    s0      = TIM_IDLE;
    addr_s0 = '0;
    if (state_q == ST_RUN) begin
      s0.hsync_n = !(hcnt_q >= H_SYNC_S && hcnt_q < H_SYNC_E);
      s0.vsync_n = !(vcnt_q >= V_SYNC_S && vcnt_q < V_SYNC_E);
      s0.de      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      s0.fs      = (hcnt_q == '0) && (vcnt_q == '0);
`ifdef VMEM_SCAN_SCALE_EN
      s0.win     = s0.de;
`else
      s0.win     = (hcnt_q < WIN_W) && (vcnt_q < WIN_H);
`endif
      if (s0.win) begin
        addr_s0 = line_base_q + VMEM_ADDRW'(hcnt_q >> S);
      end
    end
  end

  // Stage 1: address goes to vmem; timing flags wait alongside it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q         <= TIM_IDLE;
      vmem_raddr_o <= '0;
    end else begin
      s1_q         <= s0;
      vmem_raddr_o <= addr_s0;
    end
  end

  // Stage 2: vmem data is valid now; register everything to the pins together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hsync_o       <= 1'b1;
      vsync_o       <= 1'b1;
      de_o          <= 1'b0;
      rgb_o         <= '0;
      frame_start_o <= 1'b0;
    end else begin
      hsync_o       <= s1_q.hsync_n;
      vsync_o       <= s1_q.vsync_n;
      de_o          <= s1_q.de;
      rgb_o         <= s1_q.win ? vmem_rdata_i : '0;
      frame_start_o <= s1_q.fs;
    end
  end

endmodule
